shifter_sll_pipe: RTL and testbench
===================================

SHIFTER_SLL_PIPE -- requirements
Module: shifter_sll_pipe

Interface
REQ-001 The block SHALL have parameter SLL, default 6'b000000, the function code selecting a logical left shift.
REQ-002 The block SHALL have parameter STAGES, default 5, the pipeline depth; only the value 5 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input operands are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-007 The block SHALL have port dataA, input, 32 bits: the value to be shifted.
REQ-008 The block SHALL have port dataB, input, 32 bits: the shift amount; only bits [4:0] are used.
REQ-009 The block SHALL have port Signal, input, 6 bits: the function code.
REQ-010 The block SHALL have port out_valid, output, 1 bit: dataOut holds a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port dataOut, output, 32 bits: the shifted result.
REQ-013 The block SHALL have port busy, output, 1 bit: at least one pipeline stage holds a valid entry.

Function
REQ-014 An input SHALL be accepted on a rising edge when in_valid=1, in_ready=1 and Signal==SLL.
REQ-015 An input with Signal!=SLL SHALL be discarded, and no pipeline state changes because of it.
REQ-016 The pipeline SHALL advance when out_valid=0 or out_ready=1; in_ready SHALL equal this advance condition (global stall).
REQ-017 Stage k (k=0..4) SHALL shift left by 2^k when dataB[k]=1, zero-filling from bit 0; stage 0 operates on dataA.
REQ-018 Each stage register SHALL hold {valid, 32-bit data, remaining shift bits}; dataB[31:5] SHALL be ignored.
REQ-019 Latency SHALL be as follows:
- An input accepted at edge E produces out_valid=1 after edge E+4 when there is no stall.
- Each stall cycle adds one cycle of latency.
REQ-020 Throughput SHALL be one result per cycle while out_ready=1.
REQ-021 Results SHALL emerge in acceptance order, and no entry SHALL be lost or duplicated.
REQ-022 While stalled, all stage registers, dataOut and out_valid SHALL hold their values.
REQ-023 An accept and an output consume on the same edge SHALL both occur.
REQ-024 dataOut SHALL be driven from the final stage register and SHALL keep its last value while out_valid=0.
REQ-025 Shift amount 0 SHALL return dataA unchanged; shift amount 31 SHALL leave only dataA[0] at bit 31.
REQ-026 busy SHALL be the OR of all stage valid bits.
REQ-027 Bubbles SHALL travel through the pipeline; the block SHALL NOT compress them.

Reset
REQ-028 reset=0 SHALL immediately clear all stage valid bits, stage data and shift fields, asynchronously.
REQ-029 During reset, out_valid=0, dataOut=32'h0, busy=0 and in_ready=1 SHALL hold.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries without producing any output.
REQ-031 After reset deasserts, the first rising edge SHALL be able to accept an input.

Structure
REQ-032 The function codes (SLL=6'b000000, SRL=6'b000010) and the width constants (32 data bits, 5 shift bits) SHALL reside in the shared ALU package.
REQ-033 One sub-module, sll_stage, SHALL implement a single registered stage (parameter: shift distance) and SHALL be instantiated five times.
REQ-034 The stall/ready logic and the Signal decode SHALL reside in the top module only.

Verification
REQ-035 Scenario: dataA=32'h0000_0001, dataB=31, Signal=SLL, out_ready=1 -> dataOut=32'h8000_0000 with out_valid=1 after edge E+4.
REQ-036 Scenario: dataA=32'hFFFF_FFFF, dataB=32'h0000_0024 -> dataOut=32'hFFFF_FFF0 (upper dataB bits ignored).
REQ-037 Scenario: five back-to-back inputs A<<0, A<<1, A<<2, A<<3, A<<4 with A=32'h1234_5678 and out_ready=1 -> results appear on five consecutive cycles, in order.
REQ-038 Scenario: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, dataOut stable; after out_ready=1 all results drain in order.
REQ-039 Scenario: in_valid=1 with Signal=6'b000010 -> in_ready=1, busy stays 0, no out_valid.
REQ-040 Scenario: reset=0 asserted two cycles after an accept -> out_valid=0, dataOut=32'h0, busy=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/shifter_sll_pipe_pkg.sv
// Shared ALU package: function codes, widths
// and the stage register bundle of the SLL pipe.
package shifter_sll_pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int FN_W    = 6;

  localparam logic [FN_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FN_W-1:0] FN_SRL = 6'b000010;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;
  typedef logic [FN_W-1:0]    fn_t;

  typedef struct packed {
    logic   v;
    word_t  data;
    shamt_t sh;
  } sll_st_t;

  function automatic sll_st_t st_make(
    input logic   v,
    input word_t  data,
    input shamt_t sh
  );
    sll_st_t s;
    s.v    = v;
    s.data = data;
    s.sh   = sh;
    return s;
  endfunction

endpackage

// File: rtl/shifter_sll_pipe_if.sv
// Operand/result handshake bundle of the
// SLL pipe; master drives, slave computes.
interface shifter_sll_pipe_if;
  import shifter_sll_pipe_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t dataA;
  word_t dataB;
  fn_t   Signal;
  logic  out_valid;
  logic  out_ready;
  word_t dataOut;
  logic  busy;

  modport master (
    output in_valid,
    output dataA,
    output dataB,
    output Signal,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dataOut,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  dataA,
    input  dataB,
    input  Signal,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dataOut,
    output busy
  );

endinterface

// File: rtl/shifter_sll_pipe_sll_stage.sv
// One registered log-shifter stage: shifts by
// DIST when the matching shift bit is set.
module sll_stage
  import shifter_sll_pipe_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  sll_st_t d,
  output sll_st_t q
);

  localparam int K = $clog2(DIST);

  word_t shifted;

  // Conditional shift by this stage's distance
  always_comb begin
    shifted = d.data;
    if (d.sh[K]) shifted = d.data << DIST;
  end

  // Valid follows every advance; payload only
  // loads on a real entry so bubbles keep it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q.v <= d.v;
      if (d.v) begin
        q.data <= shifted;
        q.sh   <= d.sh;
      end
    end
  end

endmodule

// File: rtl/shifter_sll_pipe.sv
// Five-stage logical left shifter with a
// global-stall valid/ready handshake.
module shifter_sll_pipe
  import shifter_sll_pipe_pkg::*;
#(
  parameter fn_t SLL    = FN_SLL,
  parameter int  STAGES = 5
) (
  input  logic clk,
  input  logic reset,
  shifter_sll_pipe_if.slave bus
);

  logic    advance;
  logic    accept;
  logic    any_v;
  sll_st_t st_d [STAGES];
  sll_st_t st_q [STAGES];

  logic unused_hi;
  assign unused_hi = ^bus.dataB[DATA_W-1:SHAMT_W];

  // Whole pipe moves unless the output is held
  always_comb begin
    advance = !st_q[STAGES-1].v || bus.out_ready;
    accept  = bus.in_valid && (bus.Signal == SLL);
  end

  assign st_d[0] = st_make(
    accept,
    bus.dataA,
    bus.dataB[SHAMT_W-1:0]
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k > 0) begin : g_link
      assign st_d[k] = st_q[k-1];
    end
    sll_stage #(
      .DIST (1 << k)
    ) u_stage (
      .clk   (clk),
      .rst_n (reset),
      .en    (advance),
      .d     (st_d[k]),
      .q     (st_q[k])
    );
  end

  // Pipe occupancy for the busy flag
  always_comb begin
    any_v = 1'b0;
    for (int k = 0; k < STAGES; k++)
      any_v = any_v | st_q[k].v;
  end

  // Handshake and result outputs
  always_comb begin
    bus.in_ready  = advance;
    bus.out_valid = st_q[STAGES-1].v;
    bus.dataOut   = st_q[STAGES-1].data;
    bus.busy      = any_v;
  end

endmodule

// File: tb/tb_shifter_sll_pipe.sv
// Self-checking bench for shifter_sll_pipe:
// directed scenarios plus random traffic.
module tb_shifter_sll_pipe;

  logic clk = 1'b0;
  logic reset;

  shifter_sll_pipe_if bus ();

  shifter_sll_pipe #(
    .SLL    (6'b000000),
    .STAGES (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          mv [5];
  logic [31:0] md [5];
  logic [31:0] last_out;
  logic [31:0] q [$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
    last_out = '0;
    q.delete();
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int k = 0; k < 5; k++) b |= mv[k];
    return b;
  endfunction

  task automatic set_in(bit v, logic [31:0] a,
                        logic [31:0] b,
                        logic [5:0] sig, bit ordy);
    bus.in_valid  = v;
    bus.dataA     = a;
    bus.dataB     = b;
    bus.Signal    = sig;
    bus.out_ready = ordy;
  endtask

  task automatic check_out();
    bit rdy;
    rdy = !mv[4] || bus.out_ready;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mv[4]});
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy});
    chk("busy", {31'b0, bus.busy}, {31'b0, model_busy()});
    chk("dataOut_hold", bus.dataOut, last_out);
    if (mv[4]) begin
      chk("q_nonempty", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0) chk("order", bus.dataOut, q[0]);
    end
  endtask

  // One clock: predict from pre-edge inputs, then
  // check on the following falling edge
  task automatic tick();
    bit adv, acc, cons;
    logic [31:0] ev;
    adv  = !mv[4] || bus.out_ready;
    acc  = adv && bus.in_valid && (bus.Signal == 6'b000000);
    cons = mv[4] && bus.out_ready;
    ev   = bus.dataA << bus.dataB[4:0];
    @(posedge clk);
    if (cons) void'(q.pop_front());
    if (acc) q.push_back(ev);
    if (adv) begin
      for (int k = 4; k > 0; k--) begin
        mv[k] = mv[k-1];
        md[k] = md[k-1];
      end
      mv[0] = acc;
      md[0] = ev;
      if (mv[4]) last_out = md[4];
    end
    @(negedge clk);
    check_out();
  endtask

  logic [31:0] a37;
  logic [31:0] held;
  int          seen;
  int          first_i;
  int          last_i;

  initial begin
    reset = 1'b0;
    set_in(1'b1, 32'h1, 32'h3, 6'b0, 1'b0);
    model_clear();
    #2;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_dataOut", bus.dataOut, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;

    // first edge after release accepts
    set_in(1'b1, 32'h0000_0001, 32'd31, 6'b0, 1'b1);
    tick();
    chk("acc_first_busy", {31'b0, bus.busy}, 32'd1);
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("s035_early", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("s035_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("s035_data", bus.dataOut, 32'h8000_0000);
    for (int i = 0; i < 2; i++) tick();

    set_in(1'b1, 32'hFFFF_FFFF, 32'h0000_0024, 6'b0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("s036_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("s036_data", bus.dataOut, 32'hFFFF_FFF0);
    tick();

    a37 = 32'h1234_5678;
    for (int n = 0; n < 5; n++) begin
      set_in(1'b1, a37, n, 6'b0, 1'b1);
      tick();
    end
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    seen = 0;
    first_i = -1;
    last_i = -1;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) begin
        chk("s037_data", bus.dataOut, a37 << seen);
        if (first_i < 0) first_i = i;
        last_i = i;
        seen++;
      end
      tick();
    end
    chk("s037_count", seen, 32'd5);
    chk("s037_contig", last_i - first_i, 32'd4);

    for (int n = 0; n < 5; n++) begin
      set_in(1'b1, $urandom, $urandom, 6'b0, 1'b0);
      tick();
    end
    chk("s038_full", {31'b0, bus.out_valid}, 32'd1);
    held = bus.dataOut;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, $urandom, $urandom, 6'b0, 1'b0);
      tick();
      chk("s038_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("s038_stable", bus.dataOut, held);
    end
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("s038_drained", {31'b0, bus.busy}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, $urandom, $urandom, 6'b000010, 1'b1);
      tick();
      chk("s039_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("s039_busy", {31'b0, bus.busy}, 32'd0);
      chk("s039_ovalid", {31'b0, bus.out_valid}, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? 6'(
               $urandom_range(1, 63)) : 6'b0,
             $urandom_range(0, 3) != 0);
      tick();
    end
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();

    set_in(1'b1, 32'hDEAD_BEEF, 32'd4, 6'b0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("s040_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("s040_dataOut", bus.dataOut, 32'h0);
    chk("s040_busy", {31'b0, bus.busy}, 32'd0);
    chk("s040_in_ready", {31'b0, bus.in_ready}, 32'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check_out();
    #2 reset = 1'b1;
    set_in(1'b1, 32'h0000_00F0, 32'd8, 6'b0, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 6'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    tick();
    chk("s040_post", bus.dataOut, 32'h0000_F000);
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
